// File: rtl/stack_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// stack_xfer_ctrl
// Sequencer for multi-word push/pop through a stack-pointer register.
// Push pre-decrements SP and writes at the new SP; pop reads at the current
// SP and post-increments it. One SP step is applied per word.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, op, words    request from control unit (op: 0 push, 1 pop)
//   busy, done, err     status; done/err are one-cycle pulses
//   sp_oe_a, sp_count,  controls to the SP register
//   sp_pre_count,
//   sp_post_count
//   sp_bus              SP value as seen on bus a
//   mem_addr, mem_req,  memory port (mem_addr is latched from sp_bus)
//   mem_we, mem_ready
// ---------------------------------------------------------------------------
module stack_xfer_ctrl #(
    parameter int WORD_BYTES = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [3:0]  words,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        sp_oe_a,
    output logic [7:0]  sp_count,
    output logic        sp_pre_count,
    output logic        sp_post_count,
    input  logic [31:0] sp_bus,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ready
);

    localparam int              TW           = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      STEP_POS     = 8'(WORD_BYTES);
    localparam logic [7:0]      STEP_NEG     = 8'(-WORD_BYTES);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic            OP_PUSH      = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic            op_r;
    logic [3:0]      remaining_r;
    logic [TW-1:0]   tcnt_r;
    logic            abort_r;
    logic [31:0]     addr_r;

    // State register and per-operation bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            op_r        <= 1'b0;
            remaining_r <= 4'd0;
            tcnt_r      <= '0;
            abort_r     <= 1'b0;
            addr_r      <= 32'd0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r        <= op;
                        remaining_r <= words;
                        abort_r     <= 1'b0;
                    end
                end
                ADDR: begin
                    // SP drives the (pre-stepped for push) address this cycle
                    addr_r <= sp_bus;
                    tcnt_r <= '0;
                end
                REQ: begin
                    if (mem_ready) begin
                        remaining_r <= remaining_r - 4'd1;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                        if (tcnt_r == TIMEOUT_LAST) begin
                            abort_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (words == 4'd0) ? DONE : ADDR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADDR: state_next_s = REQ;
            REQ: begin
                if (mem_ready) begin
                    state_next_s = (remaining_r == 4'd1) ? DONE : ADDR;
                end else if (tcnt_r == TIMEOUT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = REQ;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from the state register; reset forces IDLE so every
    // SP control line drops at once and no step lands on a later edge.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        sp_oe_a       = 1'b0;
        sp_count      = 8'd0;
        sp_pre_count  = 1'b0;
        sp_post_count = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            ADDR: begin
                busy    = 1'b1;
                sp_oe_a = 1'b1;
                if (op_r == OP_PUSH) begin
                    sp_count     = STEP_NEG;
                    sp_pre_count = 1'b1;
                end else begin
                    sp_count      = STEP_POS;
                    sp_post_count = 1'b1;
                end
            end
            REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = (op_r == OP_PUSH);
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                err  = abort_r;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign mem_addr = addr_r;

endmodule

// File: tb/tb_stack_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_xfer_ctrl
// Self-checking bench: an SP register model drives sp_bus, and each operation
// is checked cycle by cycle against a schedule built from the push/pop rules
// (address list, wait/ready pattern, abort point, final SP).
// ---------------------------------------------------------------------------
module tb_stack_xfer_ctrl;

    localparam int TB_WB = 4;
    localparam int TB_TO = 4;

    localparam int K_ADDR  = 1;
    localparam int K_WAIT  = 2;
    localparam int K_READY = 3;
    localparam int K_DONE  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [3:0]  words;
    logic        busy, done, err;
    logic        sp_oe_a;
    logic [7:0]  sp_count;
    logic        sp_pre_count, sp_post_count;
    logic [31:0] sp_bus;
    logic [31:0] mem_addr;
    logic        mem_req, mem_we;
    logic        mem_ready;

    logic [31:0] sp_reg;
    logic        sp_load;
    logic [31:0] sp_load_val;
    logic [31:0] step_ext;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stack_xfer_ctrl #(.WORD_BYTES(TB_WB), .TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .words(words),
        .busy(busy), .done(done), .err(err),
        .sp_oe_a(sp_oe_a), .sp_count(sp_count),
        .sp_pre_count(sp_pre_count), .sp_post_count(sp_post_count),
        .sp_bus(sp_bus), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_we(mem_we), .mem_ready(mem_ready)
    );

    // Stack-pointer register model (cpu_reg behaviour seen from bus a)
    assign step_ext = {{24{sp_count[7]}}, sp_count};
    assign sp_bus   = sp_oe_a ? (sp_pre_count ? sp_reg + step_ext : sp_reg) : 32'h0;

    always @(posedge clk) begin
        if (sp_load) sp_reg <= sp_load_val;
        else if (sp_pre_count || sp_post_count) sp_reg <= sp_reg + step_ext;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_sp(input logic [31:0] v);
        sp_load     = 1'b1;
        sp_load_val = v;
        @(posedge clk); #1;
        sp_load = 1'b0;
    endtask

    // One operation: builds the expected cycle schedule, drives it, checks it.
    task automatic run_op(input logic op_i, input int n, input logic [31:0] sp0,
                          input int min_wait, input int max_wait,
                          input int abort_word, input bit noise);
        int          kind_q[$];
        logic [31:0] addr_q[$];
        logic [31:0] sp_m;
        logic [31:0] cur_addr;
        logic [7:0]  exp_cnt;
        bit          aborted;
        int          w;
        int          k;
        sp_m    = sp0;
        aborted = 1'b0;
        cur_addr = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (op_i == 1'b0) begin
                sp_m     = sp_m - 32'(TB_WB);
                cur_addr = sp_m;
            end else begin
                cur_addr = sp_m;
                sp_m     = sp_m + 32'(TB_WB);
            end
            kind_q.push_back(K_ADDR); addr_q.push_back(cur_addr);
            if (i == abort_word) begin
                for (int j = 0; j < TB_TO; j++) begin
                    kind_q.push_back(K_WAIT); addr_q.push_back(cur_addr);
                end
                aborted = 1'b1;
                break;
            end
            w = $urandom_range(max_wait, min_wait);
            for (int j = 0; j < w; j++) begin
                kind_q.push_back(K_WAIT); addr_q.push_back(cur_addr);
            end
            kind_q.push_back(K_READY); addr_q.push_back(cur_addr);
        end
        kind_q.push_back(K_DONE); addr_q.push_back(cur_addr);

        load_sp(sp0);
        start = 1'b1; op = op_i; words = 4'(n); mem_ready = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0; op = 1'($urandom); words = 4'($urandom);

        for (int c = 0; c < kind_q.size(); c++) begin
            k = kind_q[c];
            mem_ready = (k == K_READY) ? 1'b1 : (k == K_WAIT) ? 1'b0 : 1'($urandom);
            start     = noise ? 1'($urandom) : 1'b0;
            #1;
            exp_cnt = (k != K_ADDR) ? 8'd0 : (op_i ? 8'(TB_WB) : 8'(256 - TB_WB));
            check_val("busy", 32'(busy), 32'd1);
            check_val("done", 32'(done), 32'(k == K_DONE));
            check_val("err", 32'(err), 32'(k == K_DONE && aborted));
            check_val("mem_req", 32'(mem_req), 32'(k == K_WAIT || k == K_READY));
            check_val("mem_we", 32'(mem_we), 32'((k == K_WAIT || k == K_READY) && !op_i));
            check_val("sp_oe_a", 32'(sp_oe_a), 32'(k == K_ADDR));
            check_val("sp_pre", 32'(sp_pre_count), 32'(k == K_ADDR && !op_i));
            check_val("sp_post", 32'(sp_post_count), 32'(k == K_ADDR && op_i));
            check_val("sp_count", 32'(sp_count), 32'(exp_cnt));
            if (k == K_WAIT || k == K_READY) check_val("mem_addr", mem_addr, addr_q[c]);
            @(posedge clk); #1;
        end
        start = 1'b0;
        mem_ready = 1'b0;
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_done", 32'(done), 32'd0);
        check_val("sp_final", sp_reg, sp_m);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; words = 4'd0; mem_ready = 1'b0;
        sp_load = 1'b0; sp_load_val = 32'd0;
        @(posedge clk); #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_addr", mem_addr, 32'd0);
        check_val("rst_oe", 32'(sp_oe_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // push 1, SP=100 -> 96, ready immediately, done in cycle 3
        run_op(1'b0, 1, 32'd100, 0, 0, -1, 1'b0);
        // pop 3, SP=50 -> 50,54,58, SP=62, done in cycle 7
        run_op(1'b1, 3, 32'd50, 0, 0, -1, 1'b0);
        // push 2, SP=10, 3 wait cycles per word -> 6, 2
        run_op(1'b0, 2, 32'd10, 3, 3, -1, 1'b0);
        // timeout on a single push, SP=20 -> 16
        run_op(1'b0, 1, 32'd20, 0, 0, 0, 1'b0);
        // words=0: done in cycle 1, no activity
        run_op(1'b0, 0, 32'd77, 0, 0, -1, 1'b0);
        // start pulses during the operation are ignored
        run_op(1'b1, 2, 32'd5, 1, 2, -1, 1'b1);
        // wrap through zero
        run_op(1'b0, 2, 32'd4, 0, 1, -1, 1'b0);

        // reset during REQ
        load_sp(32'd300);
        start = 1'b1; op = 1'b0; words = 4'd2; mem_ready = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_req", 32'(mem_req), 32'd0);
        check_val("mid_rst_oe", 32'(sp_oe_a), 32'd0);
        check_val("mid_rst_pre", 32'(sp_pre_count), 32'd0);
        check_val("mid_rst_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("mid_rst_sp", sp_reg, 32'd296);
        check_val("mid_rst_idle", 32'(busy), 32'd0);
        run_op(1'b1, 1, 32'd296, 0, 1, -1, 1'b0);

        // randomized operations
        for (int t = 0; t < 40; t++) begin
            int          n_r;
            int          ab;
            logic [31:0] sp_r0;
            n_r   = $urandom_range(15, 0);
            ab    = (n_r > 0 && ($urandom_range(4, 0) == 0)) ? int'($urandom_range(n_r - 1, 0)) : -1;
            sp_r0 = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
            run_op(1'($urandom), n_r, sp_r0, 0, TB_TO - 1, ab, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_xfer_ctrl.md
Name: stack_xfer_ctrl

Overview:
Sequencer that drives a cpu_reg used as stack pointer (SP), through its count/pre_count/post_count/oe_a controls, and runs the matching memory transactions for multi-word push/pop.
- Push: pre-decrement SP, then write at the new SP.
- Pop: read at the current SP, then post-increment SP.
- Sits between the control unit (start/done) and the SP register plus the memory port; SP bus output is sampled on bus a.

Parameters:
WORD_BYTES, 1, SP step per word; must be 1..127; applied as an 8-bit two's-complement count.
TIMEOUT, 255, max REQ cycles per word waiting for mem_ready before abort; must be ≥1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request operation; sampled only in IDLE
op  input  1  0 = push, 1 = pop
words  input  4  number of words to transfer (0..15)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse, coincident with done, on timeout abort
sp_oe_a  output  1  to SP: drive value onto bus a
sp_count  output  8  to SP: signed step
sp_pre_count  output  1  to SP: bus shows value+count; SP updates at the edge
sp_post_count  output  1  to SP: bus shows value; SP updates to value+count at the edge
sp_bus  input  32  bus a as driven by SP
mem_addr  output  32  latched transfer address
mem_req  output  1  memory request
mem_we  output  1  1 = write (push), 0 = read (pop)
mem_ready  input  1  memory accepts/completes the current word

Behaviour:
- Reset (async, immediate, including mid-operation):
  - state = IDLE; all outputs 0; mem_addr = 0; internal op, remaining-word counter and timeout counter cleared.
  - SP control lines drop in the same instant, so no count is applied at a following edge.
- States are IDLE, ADDR, REQ, DONE. sp_* outputs are 0 in every state except ADDR.
- IDLE:
  - start=1 with words=0 goes to DONE; no SP or memory activity.
  - start=1 with words≠0 latches op, sets remaining=words and goes to ADDR.
  - mem_ready is ignored.
- ADDR (exactly one cycle per word):
  - sp_oe_a=1.
  - Push: sp_count = −WORD_BYTES, sp_pre_count=1.
  - Pop: sp_count = +WORD_BYTES, sp_post_count=1.
  - mem_addr ← sp_bus at the closing edge. Timeout counter cleared. Next state REQ.
- REQ:
  - mem_req=1, mem_we = (op==push); mem_addr stable.
  - If mem_ready=1 at an edge: remaining −= 1. Go to DONE if remaining was 1, otherwise to ADDR.
  - If mem_ready=0: timeout counter +1. When it reaches TIMEOUT, go to DONE with the abort flag set.
  - SP has already been updated for the aborted word; the controller does not roll it back.
- DONE (one cycle): done=1; err=1 only if aborted; busy=1. Next state IDLE.
- start while busy is ignored, not queued. op/words changes after the start cycle have no effect.
- Exactly one SP count is applied per word, regardless of how many wait cycles mem_ready takes.
- Latency: with mem_ready high on the first REQ cycle, N words take 2N cycles from the start edge to DONE. done is asserted in cycle 2N+1 after start (start sampled = cycle 0).
- sp_count sign-extends in SP. Address wrap-around (0 − 1 = 0xFFFFFFFF) is SP's behaviour; the controller just latches the bus.

Test Plan:
- Push 1 word, SP=100, WORD_BYTES=1, mem_ready tied high → ADDR cycle shows sp_bus=99; mem_addr=99, mem_we=1 in REQ; SP=99 after; done pulse in cycle 3; err=0.
- Pop 3 words, SP=50, mem_ready high → mem_addr sequence 50, 51, 52 with mem_we=0; SP=53 at done; done in cycle 7.
- Push 2 words, SP=10, WORD_BYTES=4, mem_ready low for 3 REQ cycles per word → mem_addr 6 then 2; SP=2; exactly two sp_pre_count pulses; mem_req held through the waits.
- TIMEOUT=4, push 1 word, SP=20, mem_ready held low → after 4 REQ cycles done=1 and err=1 together; SP=19; back in IDLE next cycle.
- words=0 start → done in cycle 1 with no sp_* or mem_req activity. A start pulse during REQ of another operation is ignored: one done only.
- rst asserted mid-REQ → busy, mem_req and sp_* go to 0 immediately; SP unchanged after release; next start runs normally.
